// File: rtl/mux_scan_nto1.sv
// ============================================================================
// Module   : mux_scan_nto1
// Brief    : Registered N-to-1 mux with manual select and timed channel scan.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_scan_nto1 #(
  parameter  int WIDTH    = 1,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 4,
  localparam int SW       = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] w,
  input  logic [SW-1:0]             sel,
  input  logic                      mode,
  input  logic                      en,
  output logic [WIDTH-1:0]          f,
  output logic [SW-1:0]             ch,
  output logic                      valid,
  output logic                      wrap
);

  localparam int              c_DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [c_DW-1:0] c_DLAST = c_DW'(DWELL - 1);
  localparam logic [SW-1:0]   c_PLAST = SW'(CHANNELS - 1);
  localparam logic [SW:0]     c_NCH   = (SW + 1)'(CHANNELS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MANUAL = 2'd1,
    S_SCAN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     p_q, p_d;
  logic [c_DW-1:0]   dwell_q, dwell_d;
  logic [WIDTH-1:0]  f_q, f_d;
  logic [SW-1:0]     ch_q, ch_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;

  logic              w_in_scan;
  logic              w_sel_ok;
  logic [SW-1:0]     w_p_eff;
  logic [c_DW-1:0]   w_d_eff;
  logic [WIDTH-1:0]  w_sel_data;
  logic [WIDTH-1:0]  w_scan_data;

  // Scan position only survives while already scanning; any entry restarts at 0.
  assign w_in_scan = (state_q == S_SCAN);
  assign w_p_eff   = w_in_scan ? p_q : '0;
  assign w_d_eff   = w_in_scan ? dwell_q : '0;
  assign w_sel_ok  = ({1'b0, sel} < c_NCH);

  always_comb begin
    w_sel_data  = '0;
    w_scan_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(sel) == i)     w_sel_data  = w[i*WIDTH +: WIDTH];
      if (int'(w_p_eff) == i) w_scan_data = w[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    dwell_d = dwell_q;
    f_d     = f_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    if (en) begin
      if (!mode) begin
        state_d = S_MANUAL;
        p_d     = '0;
        dwell_d = '0;
        if (w_sel_ok) begin
          f_d     = w_sel_data;
          ch_d    = sel;
          valid_d = 1'b1;
        end else begin
          f_d     = '0;
          valid_d = 1'b0;
        end
      end else begin
        state_d = S_SCAN;
        f_d     = w_scan_data;
        ch_d    = w_p_eff;
        valid_d = 1'b1;
        // Pointer at 0 with a fresh dwell while already scanning means we just wrapped.
        wrap_d  = w_in_scan && (p_q == '0) && (dwell_q == '0);
        if (w_d_eff == c_DLAST) begin
          dwell_d = '0;
          p_d     = (w_p_eff == c_PLAST) ? '0 : w_p_eff + 1'b1;
        end else begin
          dwell_d = w_d_eff + 1'b1;
          p_d     = w_p_eff;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      dwell_q <= '0;
      f_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      dwell_q <= dwell_d;
      f_q     <= f_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign f     = f_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_nto1.sv
// ============================================================================
// Module   : tb_mux_scan_nto1
// Brief    : Scoreboard bench for mux_scan_nto1 across four configurations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mux_scan_nto1;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic       en;
  logic [1:0] sel;

  logic [7:0] wa;
  logic [3:0] wb;
  logic [2:0] wc;
  logic [1:0] wd;

  logic [1:0] fa, cha;
  logic       va, wra;
  logic [0:0] fb;
  logic [1:0] chb;
  logic       vb, wrb;
  logic [0:0] fc;
  logic [1:0] chc;
  logic       vc, wrc;
  logic [0:0] fd;
  logic [0:0] chd;
  logic       vd, wrd;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] f;
    logic [1:0] ch;
    logic       v;
    logic       wr;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  // A: scan/mode tests, B: 4-ch manual, C: 3-ch illegal select, D: DWELL=1 alternation
  mux_scan_nto1 #(.WIDTH(2), .CHANNELS(4), .DWELL(4)) u_a (
    .clk(clk), .rst(rst), .w(wa), .sel(sel), .mode(mode), .en(en),
    .f(fa), .ch(cha), .valid(va), .wrap(wra));
  mux_scan_nto1 #(.WIDTH(1), .CHANNELS(4), .DWELL(4)) u_b (
    .clk(clk), .rst(rst), .w(wb), .sel(sel), .mode(mode), .en(en),
    .f(fb), .ch(chb), .valid(vb), .wrap(wrb));
  mux_scan_nto1 #(.WIDTH(1), .CHANNELS(3), .DWELL(4)) u_c (
    .clk(clk), .rst(rst), .w(wc), .sel(sel), .mode(mode), .en(en),
    .f(fc), .ch(chc), .valid(vc), .wrap(wrc));
  mux_scan_nto1 #(.WIDTH(1), .CHANNELS(2), .DWELL(1)) u_d (
    .clk(clk), .rst(rst), .w(wd), .sel(sel[0]), .mode(mode), .en(en),
    .f(fd), .ch(chd), .valid(vd), .wrap(wrd));

  // Monitor: one expectation is consumed per rising edge, sampled 1 time unit later.
  always @(posedge clk) begin
    exp_t       e;
    logic [5:0] act;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      case (e.id)
        2'd0:    act = {fa, cha, va, wra};
        2'd1:    act = {1'b0, fb, chb, vb, wrb};
        2'd2:    act = {1'b0, fc, chc, vc, wrc};
        default: act = {1'b0, fd, 1'b0, chd, vd, wrd};
      endcase
      n_checks++;
      if (act !== {e.f, e.ch, e.v, e.wr}) begin
        n_fail++;
        $display("FAIL sb_dut%0d t=%0t: got f=%0d ch=%0d valid=%0b wrap=%0b, want f=%0d ch=%0d valid=%0b wrap=%0b",
                 e.id, $time, act[5:4], act[3:2], act[1], act[0], e.f, e.ch, e.v, e.wr);
      end
    end
  end

  task automatic step(input logic m, input logic e, input logic [1:0] s,
                      input logic [1:0] id, input logic [1:0] ef, input logic [1:0] ec,
                      input logic ev, input logic ewr, input bit chk);
    exp_t x;
    @(negedge clk);
    mode = m;
    en   = e;
    sel  = s;
    if (chk) begin
      x = '{id: id, f: ef, ch: ec, v: ev, wr: ewr};
      q.push_back(x);
    end
  endtask

  task automatic check_zero(input string name, input logic [5:0] act);
    n_checks++;
    if (act !== 6'd0) begin
      n_fail++;
      $display("FAIL %s: got {f,ch,valid,wrap}=%b, want 000000", name, act);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] c;
    exp_t       x;
    rst  = 1'b1;
    en   = 1'b0;
    mode = 1'b0;
    sel  = 2'd0;
    wa   = {2'd3, 2'd2, 2'd1, 2'd0};
    wb   = 4'b1010;
    wc   = 3'b101;
    wd   = 2'b10;
    repeat (2) @(negedge clk);
    check_zero("reset_a", {fa, cha, va, wra});
    check_zero("reset_d", {1'b0, fd, 1'b0, chd, vd, wrd});
    rst = 1'b0;

    // Disabled edge in IDLE holds the reset outputs
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);

    // Scan: channel k on edges 4k+1..4k+4, 3-cycle stall inside channel 1
    for (int k = 1; k <= 6; k++) begin
      c = 2'((k - 1) / 4);
      step(1, 1, 0, 0, c, c, 1, 0, 1);
    end
    repeat (3) step(1, 0, 0, 0, 1, 1, 1, 0, 1);
    for (int k = 7; k <= 16; k++) begin
      c = 2'((k - 1) / 4);
      step(1, 1, 0, 0, c, c, 1, 0, 1);
    end
    step(1, 1, 0, 0, 0, 0, 1, 1, 1);
    step(1, 1, 0, 0, 0, 0, 1, 0, 1);

    // Data change on the displayed channel mid-dwell shows one edge later
    @(negedge clk);
    wa[1:0] = 2'd2;
    x = '{id: 2'd0, f: 2'd2, ch: 2'd0, v: 1'b1, wr: 1'b0};
    q.push_back(x);
    @(negedge clk);
    wa[1:0] = 2'd0;
    x = '{id: 2'd0, f: 2'd0, ch: 2'd0, v: 1'b1, wr: 1'b0};
    q.push_back(x);
    for (int k = 21; k <= 26; k++) begin
      c = 2'((k - 17) / 4);
      step(1, 1, 0, 0, c, c, 1, 0, 1);
    end

    // Mode switch during channel 2, then back to scan restarts at 0
    step(0, 1, 3, 0, 3, 3, 1, 0, 1);
    step(1, 1, 3, 0, 0, 0, 1, 0, 1);
    repeat (3) step(1, 1, 3, 0, 0, 0, 1, 0, 1);
    step(1, 1, 3, 0, 1, 1, 1, 0, 1);

    // Manual on 4 channels of 1 bit, w=1010
    step(0, 1, 0, 1, 0, 0, 1, 0, 1);
    step(0, 1, 1, 1, 1, 1, 1, 0, 1);
    step(0, 1, 2, 1, 0, 2, 1, 0, 1);
    step(0, 1, 3, 1, 1, 3, 1, 0, 1);

    // Three channels, w=101: out-of-range select drops valid, holds ch
    step(0, 1, 1, 2, 0, 1, 1, 0, 1);
    step(0, 1, 2, 2, 1, 2, 1, 0, 1);
    step(0, 1, 3, 2, 0, 2, 0, 0, 1);
    step(0, 1, 0, 2, 1, 0, 1, 0, 1);

    // DWELL=1, two channels, w=10: alternation with wrap on each return to 0
    step(0, 1, 0, 3, 0, 0, 1, 0, 1);
    step(1, 1, 0, 3, 0, 0, 1, 0, 1);
    step(1, 1, 0, 3, 1, 1, 1, 0, 1);
    step(1, 1, 0, 3, 0, 0, 1, 1, 1);
    step(1, 1, 0, 3, 1, 1, 1, 0, 1);
    step(1, 1, 0, 3, 0, 0, 1, 1, 1);

    // Asynchronous reset between edges while scanning
    repeat (5) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero("async_rst_a", {fa, cha, va, wra});
    check_zero("async_rst_d", {1'b0, fd, 1'b0, chd, vd, wrd});
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 2, 0, 2, 2, 1, 0, 1);

    repeat (3) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
